// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/operand request and registered result signals of the BCD converter.
interface bcd_to_bin_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14
) ();

    logic                    enable_in;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    busy;
    logic                    done;
    logic                    err_flag;
    logic [BIN_WIDTH-1:0]    bin_out;

    modport master (
        output enable_in, bcd_in,
        input  busy, done, err_flag, bin_out
    );

    modport slave (
        input  enable_in, bcd_in,
        output busy, done, err_flag, bin_out
    );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step, built from shifts and adds only.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int unsigned W = 14
) (
    input  logic [W-1:0]           acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [W-1:0]           acc_next
);

    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + W'(digit);
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Serial packed-BCD to binary converter, one digit per clock, MSD first.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14
) (
    input  logic         clk,
    input  logic         reset,
    bcd_to_bin_if.slave  bus
);

    localparam int unsigned OPND_W = BCD_DIGIT_W * NUM_DIGITS;
    localparam int unsigned CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    bcd_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OPND_W-1:0]      opnd_q, opnd_d;
    logic [BIN_WIDTH-1:0]   acc_q, acc_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [BCD_DIGIT_W-1:0] digit;
    logic [BIN_WIDTH-1:0]   mac_out;
    logic                   digit_bad;
    logic                   last_digit;

    // The captured operand shifts left each step so the current digit is always the top nibble.
    assign digit      = opnd_q[OPND_W-1 -: BCD_DIGIT_W];
    assign digit_bad  = bcd_digit_bad(digit);
    assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

    bcd_mac10 #(.W(BIN_WIDTH)) u_mac10 (
        .acc      (acc_q),
        .digit    (digit),
        .acc_next (mac_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.enable_in) begin
                    opnd_d  = bus.bcd_in;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                acc_d  = mac_out;
                cnt_d  = cnt_q + CNT_W'(1);
                opnd_d = opnd_q << BCD_DIGIT_W;
                if (digit_bad) begin
                    err_d = 1'b1;
                end
                if (last_digit) begin
                    bin_d   = (err_q || digit_bad) ? '0 : mac_out;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err_flag = err_q;
    assign bus.bin_out  = bin_q;

endmodule
